bin_to_bcd_seq_ctrl: RTL and testbench
======================================

Name: bin_to_bcd_seq_ctrl

Overview:
Multi-cycle binary-to-BCD converter controller that runs the shift-and-add-3 (double dabble) algorithm one iteration per clock. It replaces the single-cycle combinational converter wherever timing or area matters, such as display drivers for score, counter and timer values. Operands are accepted with a valid/ready handshake. BCD results are returned with a valid/ready handshake and held stable until consumed.

Parameters:
BIN_W, 8, width of the unsigned binary operand.
NDIG, 3, number of BCD digits produced. Must satisfy 10^NDIG > 2^BIN_W - 1; an elaboration-time check fails otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  operand on bin_i is valid.
in_ready  output  1  block can accept an operand (high only in IDLE).
bin_i  input  BIN_W  unsigned binary operand.
out_valid  output  1  bcd_o holds a finished result.
out_ready  input  1  consumer accepts the result.
bcd_o  output  4*NDIG  packed BCD result; digit k at bits [4k+3:4k], digit 0 is units.
busy  output  1  high in CONV or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, shift register=0, iteration counter=0, out_valid=0, bcd_o=0, busy=0. in_ready follows state, so it reads 1, but nothing is captured while rst_n is low.
- State machine: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: load the shift register as {NDIG*4 zeros, bin_i}, clear the counter, go to CONV.
  - in_valid=0: stay in IDLE.
- CONV, one iteration per edge:
  - First, every digit field whose value is >=5 gets +3, within 4 bits.
  - Then the whole {bcd, bin} register shifts left by 1 and the counter increments.
  - When the counter reaches BIN_W-1 on an edge, that edge does the last iteration, latches the result into bcd_o and goes to DONE.
- DONE:
  - out_valid=1; bcd_o is stable.
  - A rising edge with out_ready=1 goes to IDLE and sets out_valid=0. bcd_o keeps its last value.
  - out_ready=0: hold indefinitely with no change.
- Latency: out_valid rises exactly BIN_W clocks after the accepting edge.
- Minimum operand spacing is BIN_W+2 clocks when out_ready is tied high.
- in_valid during CONV or DONE: ignored, since in_ready=0. Upstream must hold the operand until in_ready.
- No overlap: a new operand is never accepted on the same edge as result consumption, because in_ready=0 in DONE.
- bcd_o changes only on the edge entering DONE.
- Arithmetic: each digit is 4 bits and never exceeds 9 after conversion. The shift register is BIN_W+4*NDIG bits. The counter is $clog2(BIN_W) bits, minimum 1.
- Reset mid-operation (CONV or DONE): conversion is abandoned, all registers return to reset values immediately, and no out_valid is produced for the abandoned operand.
- Operand bounds: bin_i=0 gives all-zero digits; bin_i=2^BIN_W-1 gives its exact decimal value. Leading digits are 0 with no blanking.

Decomposition:
- Shared package bcd_pkg:
  - state encoding (ST_IDLE, ST_CONV, ST_DONE);
  - digit-width constant BCD_DIG_W=4;
  - function ndig_min(bin_w), returning the digits needed, used by the elaboration check.
- Sub-module bcd_digit_adj: 4-bit in to 4-bit out, adds 3 when the input is >=5. Instantiated NDIG times via generate inside the CONV datapath.

Test Plan:
- Reset, then bin_i=0 with in_valid for 1 cycle -> out_valid rises 8 clocks later, bcd_o=12'h000, busy high for CONV and DONE.
- bin_i=255 -> bcd_o=12'h255; bin_i=100 -> 12'h100; bin_i=99 -> 12'h099, each 8 clocks after accept.
- Backpressure: bin_i=173, out_ready=0 for 6 cycles after out_valid -> bcd_o=12'h173 held, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
- in_valid held high with a changing bin_i during CONV -> the captured operand is unaffected; the result is the first value only.
- rst_n pulsed low 3 clocks after accepting 200 -> out_valid never asserts; bcd_o=0, state IDLE, next operand 42 -> 12'h042.
- Exhaustive 0..255 back-to-back with out_ready=1 and random in_valid gaps -> every result matches the decimal reference model; spacing >=10 clocks.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit width and the digit-count helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int BCD_DIG_W = 4;

   // Smallest digit count whose decimal range covers 2^bin_w - 1.
   function automatic int ndig_min(input int bin_w);
      longint unsigned maxv;
      longint unsigned p10;
      int n;
      maxv = (64'd1 << bin_w) - 64'd1;
      p10  = 64'd10;
      n    = 1;
      while (p10 <= maxv) begin
         p10 = p10 * 64'd10;
         n   = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIG_W-1:0] d,
   output logic [BCD_DIG_W-1:0] q
);

   assign q = (d >= BCD_DIG_W'(5)) ? d + BCD_DIG_W'(3) : d;

endmodule

// File: rtl/bin_to_bcd_seq_ctrl.sv
// Multi-cycle binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// valid/ready handshakes on both the operand and the result side.
module bin_to_bcd_seq_ctrl
   import bcd_pkg::*;
#(
   parameter int BIN_W = 8,
   parameter int NDIG  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BIN_W-1:0]          bin_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BCD_DIG_W*NDIG-1:0] bcd_o,
   output logic                      busy
);

   localparam int BCD_W = BCD_DIG_W * NDIG;
   localparam int SR_W  = BIN_W + BCD_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   if (NDIG < ndig_min(BIN_W)) begin : g_ndig_check
      $error("bin_to_bcd_seq_ctrl: NDIG too small for BIN_W");
   end

   state_t             state;
   logic [SR_W-1:0]    sr;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   adj;
   logic [SR_W-1:0]    sr_next;

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      bcd_digit_adj u_adj (
         .d (sr[BIN_W + BCD_DIG_W*k +: BCD_DIG_W]),
         .q (adj[BCD_DIG_W*k +: BCD_DIG_W])
      );
   end

   // Correct every digit first, then shift the whole {bcd, bin} register left by one.
   assign sr_next  = {adj, sr[BIN_W-1:0]} << 1;
   assign in_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sr        <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         bcd_o     <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sr    <= {{BCD_W{1'b0}}, bin_i};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_CONV;
               end
            end
            ST_CONV: begin
               sr  <= sr_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  bcd_o     <= sr_next[SR_W-1:BIN_W];
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq_ctrl.sv
// Directed and exhaustive bench for bin_to_bcd_seq_ctrl (BIN_W=8, NDIG=3).
module tb_bin_to_bcd_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  bin_i = 8'd0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [11:0] bcd_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_accept = 0;

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[10];

   bin_to_bcd_seq_ctrl #(.BIN_W(8), .NDIG(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_i     (bin_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_o     (bcd_o),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Wait for in_ready, present the operand for exactly one accepting edge.
   task applyStimulus(input logic [7:0] b);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      bin_i    = b;
      @(negedge clk);
      in_valid    = 1'b0;
      last_accept = cyc;
   endtask

   task waitResult(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'((v / 100) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   initial begin
      int lat;
      int prev_accept;
      int seen;

      vecs[0] = '{8'd0,   12'h000};
      vecs[1] = '{8'd255, 12'h255};
      vecs[2] = '{8'd100, 12'h100};
      vecs[3] = '{8'd99,  12'h099};
      vecs[4] = '{8'd1,   12'h001};
      vecs[5] = '{8'd9,   12'h009};
      vecs[6] = '{8'd10,  12'h010};
      vecs[7] = '{8'd128, 12'h128};
      vecs[8] = '{8'd42,  12'h042};
      vecs[9] = '{8'd199, 12'h199};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset bcd_o", 32'(bcd_o), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors, result held in DONE then consumed
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].bin);
         checkOutput("busy in CONV", 32'(busy), 32'd1);
         checkOutput("in_ready in CONV", 32'(in_ready), 32'd0);
         waitResult(lat);
         checkOutput("latency", 32'(lat), 32'd8);
         checkOutput("bcd result", 32'(bcd_o), 32'(vecs[i].exp));
         checkOutput("busy in DONE", 32'(busy), 32'd1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         checkOutput("out_valid after consume", 32'(out_valid), 32'd0);
         checkOutput("in_ready after consume", 32'(in_ready), 32'd1);
         checkOutput("busy after consume", 32'(busy), 32'd0);
         checkOutput("bcd held after consume", 32'(bcd_o), 32'(vecs[i].exp));
      end

      // Backpressure: result held for 6 cycles, stray operand ignored
      applyStimulus(8'd173);
      waitResult(lat);
      checkOutput("bp latency", 32'(lat), 32'd8);
      in_valid = 1'b1;
      bin_i    = 8'd5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("bp bcd held", 32'(bcd_o), 32'h173);
         checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
         checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bp in_ready after release", 32'(in_ready), 32'd1);
      checkOutput("bp out_valid after release", 32'(out_valid), 32'd0);

      // in_valid held high with a changing operand during CONV
      in_valid = 1'b1;
      bin_i    = 8'd77;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
         bin_i = 8'($urandom_range(0, 255));
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      checkOutput("held-valid latency", 32'(lat), 32'd8);
      checkOutput("held-valid bcd", 32'(bcd_o), 32'h077);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the middle of a conversion
      applyStimulus(8'd200);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset bcd_o", 32'(bcd_o), 32'd0);
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("no result after abort", 32'(seen), 32'd0);
      applyStimulus(8'd42);
      waitResult(lat);
      checkOutput("post-reset latency", 32'(lat), 32'd8);
      checkOutput("post-reset bcd", 32'(bcd_o), 32'h042);
      out_ready = 1'b1;
      @(negedge clk);

      // Exhaustive sweep, out_ready tied high, random idle gaps
      prev_accept = -100;
      for (int v = 0; v < 256; v++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(8'(v));
         if (v > 0)
            checkOutput("sweep spacing >= 10", 32'(last_accept - prev_accept >= 10), 32'd1);
         prev_accept = last_accept;
         waitResult(lat);
         checkOutput("sweep latency", 32'(lat), 32'd8);
         checkOutput("sweep bcd", 32'(bcd_o), 32'(ref_bcd(v)));
      end
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
